key_pulse_gen: RTL and testbench
================================

Name: key_pulse_gen

Overview:
- Upstream conditioning stage for the 8-bit T-flip-flop counter with hex display; its pulse output drives the counter's en input.
- Synchronises a raw pushbutton, debounces press and release, and emits exactly one clk-wide pulse per confirmed press.
- Optional auto-repeat: a held button emits further pulses at a fixed rate, so the counter can be stepped quickly without mashing the key.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synced input must stay stable to confirm a press or release (10 ms @ 50 MHz); must be >= 2.
- HOLD_CYCLES, 25000000: cycles in HELD before the first auto-repeat pulse; must be >= 2.
- REPEAT_CYCLES, 5000000: period between auto-repeat pulses; must be >= 2.
- CNT_W, 25: timer width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) - 1.
- ACTIVE_LOW, 1: 1 means btn_raw=0 is pressed (board KEY style); 0 means btn_raw=1 is pressed.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset; synchronous, active-high.
- btn_raw  in  1  asynchronous, bouncing pushbutton level.
- repeat_en  in  1  1 enables auto-repeat while held; sampled every cycle.
- pulse  out  1  one-cycle strobe per confirmed press or repeat; registered.
- level  out  1  debounced pressed level; registered.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Input path:
  - pressed = btn_raw XOR ACTIVE_LOW.
  - Two-flop synchroniser produces p_s; both flops reset to 0 (released).
  - FSM sees only p_s.
- Reset:
  - clr=1 at an edge overrides everything and applies on that edge: state=IDLE, timer=0, pulse=0, level=0, busy=0, synchroniser flops=0.
  - Applies equally mid-debounce, in HELD or in REPEAT.
  - No pulse is ever emitted on the edge where clr=1.
- Timer: CNT_W-bit up-counter, cleared on every state transition, never wraps (each state leaves or clears it before the limit).
- States:
  - IDLE: level=0. p_s=1 -> PRESS_CHK.
  - PRESS_CHK:
    - p_s=0 -> IDLE; treated as bounce, no pulse.
    - Otherwise timer++.
    - When timer==DEBOUNCE_CYCLES-1 and p_s=1 -> HELD, with pulse=1 and level=1 on that edge.
  - HELD: level=1.
    - p_s=0 -> REL_CHK.
    - repeat_en=0 -> timer held at 0.
    - Otherwise timer++; at timer==HOLD_CYCLES-1 -> REPEAT, with pulse=1.
  - REPEAT: level=1.
    - p_s=0 -> REL_CHK.
    - repeat_en=0 -> HELD, timer=0, no pulse.
    - Otherwise timer++; at timer==REPEAT_CYCLES-1 -> pulse=1 and timer=0, staying in REPEAT.
  - REL_CHK: level stays 1.
    - p_s=1 -> HELD, timer=0, no pulse; release bounce does not generate a new press.
    - Otherwise timer++; at timer==DEBOUNCE_CYCLES-1 -> IDLE, with level=0 on that edge.
- Latency:
  - Edge 0 is the first edge that samples pressed. The first pulse is high during the cycle after edge DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)th edge.
  - Releasing from HELD drops level on the same edge count.
- Repeat cadence:
  - First repeat comes HOLD_CYCLES edges after the press pulse.
  - Subsequent repeats come every REPEAT_CYCLES edges.
- Pulse shape: pulse is high for exactly one cycle and is never high on two consecutive cycles.
- Simultaneous events: p_s change on the same edge a timer limit is reached -> p_s takes priority (bounce/release branch wins; no pulse).

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1):
- Reset: hold clr=1 for 3 cycles with btn_raw=0 -> pulse=0, level=0, busy=0 throughout. Release clr with btn_raw=0 held -> single pulse 7 edges later.
- Clean press: btn_raw 1->0, held 20 cycles, repeat_en=0 -> exactly one pulse, at relative edge 7; level=1 from edge 7. Release -> level=0 at 7th edge after release.
- Press bounce: btn_raw=0 for 2 cycles, then 1 -> pulse never asserts, level=0, busy returns to 0.
- Auto-repeat: repeat_en=1, btn_raw=0 for 30 cycles -> pulses at relative edges 7, 17, 20, 23, 26, 29.
- Release glitch: in HELD, btn_raw=1 for 2 cycles then 0 -> level stays 1, no extra pulse. Then a true release, followed 20 cycles later by a press -> exactly one new pulse.
- clr mid-PRESS_CHK, plus an integration check:
  - Assert clr at relative edge 4 of a press -> no pulse; clr low with button held -> pulse 7 edges later.
  - Five clean presses into the counter -> HEX0 shows 5, HEX1 shows 0.

Source files
------------

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: pushbutton conditioner. Synchronises a raw bouncing key,
// debounces both press and release, and emits one clk-wide strobe per
// confirmed press, with optional auto-repeat while the key stays held.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic pulse,
  output logic level,
  output logic busy
);

  localparam int SYNC_STAGES = 2;

  // Terminal counts; the timer is compared against these and cleared on
  // every state change, so it never needs to wrap.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    REL_CHK   = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       timer_reg, timer_next;
  logic                   pulse_reg, pulse_next;
  logic                   level_reg, level_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   pressed;
  logic                   p_s;

  // Normalise polarity so that 1 always means "pressed" from here on.
  assign pressed = btn_raw ^ (ACTIVE_LOW != 0);
  assign p_s     = sync_reg[SYNC_STAGES-1];

  // Two-flop synchroniser for the asynchronous key level; resets to released.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pressed};
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      pulse_reg <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      pulse_reg <= pulse_next;
      level_reg <= level_next;
    end
  end

  // Next-state logic. A change on p_s is checked before any timer limit so
  // a bounce or release on the limit edge never produces a pulse.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pulse_next = 1'b0;
    level_next = level_reg;
    unique case (state_reg)
      IDLE: begin
        level_next = 1'b0;
        timer_next = '0;
        if (p_s) begin
          state_next = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (!p_s) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer_reg == DEB_LAST) begin
          state_next = HELD;
          timer_next = '0;
          pulse_next = 1'b1;
          level_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      HELD: begin
        level_next = 1'b1;
        if (!p_s) begin
          state_next = REL_CHK;
          timer_next = '0;
        end else if (!repeat_en) begin
          timer_next = '0;
        end else if (timer_reg == HOLD_LAST) begin
          state_next = REPEAT;
          timer_next = '0;
          pulse_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      REPEAT: begin
        level_next = 1'b1;
        if (!p_s) begin
          state_next = REL_CHK;
          timer_next = '0;
        end else if (!repeat_en) begin
          state_next = HELD;
          timer_next = '0;
        end else if (timer_reg == REP_LAST) begin
          timer_next = '0;
          pulse_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      REL_CHK: begin
        level_next = 1'b1;
        if (p_s) begin
          // Release bounce: return to HELD without a fresh press pulse.
          state_next = HELD;
          timer_next = '0;
        end else if (timer_reg == DEB_LAST) begin
          state_next = IDLE;
          timer_next = '0;
          level_next = 1'b0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign pulse = pulse_reg;
  assign level = level_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with small timing parameters.
// Edge k of a step is the k-th rising edge after the input change;
// outputs are sampled 1 ns after each edge.
module tb_key_pulse_gen;

  localparam logic [63:0] P7 = 64'd1 << 7;
  localparam logic [63:0] NONE = 64'd0;
  localparam logic [63:0] REP_MASK = (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 20)
                                   | (64'd1 << 23) | (64'd1 << 26) | (64'd1 << 29);

  logic clk = 1'b0;
  logic clr;
  logic btn_raw;
  logic repeat_en;
  logic pulse;
  logic level;
  logic busy;

  int   n_assert = 0;
  int   n_fail = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] pulse_total = 8'd0;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3),
    .CNT_W(5),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .btn_raw(btn_raw),
    .repeat_en(repeat_en),
    .pulse(pulse),
    .level(level),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock step; also checks pulse never stays high two cycles running
  // and tallies pulses for the downstream counter model.
  task automatic tick();
    @(posedge clk);
    #1;
    check("no_double_pulse", 32'(pulse & prev_pulse), 32'd0);
    prev_pulse = pulse;
    if (pulse === 1'b1) pulse_total = pulse_total + 8'd1;
  endtask

  task automatic run_seq(input string tag, input int n, input logic [63:0] pmask,
                         input logic lvl_before, input int lvl_edge, input logic lvl_after);
    for (int k = 1; k <= n; k++) begin
      tick();
      check({tag, "_pulse"}, 32'(pulse), 32'(pmask[k]));
      check({tag, "_level"}, 32'(level), 32'((k >= lvl_edge) ? lvl_after : lvl_before));
    end
    $display("%s: %0d edges checked", tag, n);
  endtask

  task automatic press(input string tag);
    btn_raw = 1'b0;
    run_seq(tag, 10, P7, 1'b0, 7, 1'b1);
  endtask

  task automatic release_key(input string tag);
    btn_raw = 1'b1;
    run_seq(tag, 10, NONE, 1'b1, 7, 1'b0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with the key pressed: nothing may come out.
    clr = 1'b1;
    btn_raw = 1'b0;
    repeat_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_pulse", 32'(pulse), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    $display("reset: 3 cycles checked");
    clr = 1'b0;
    run_seq("rst_release", 10, P7, 1'b0, 7, 1'b1);
    release_key("rst_unpress");

    // Clean long press without repeat: exactly one pulse.
    btn_raw = 1'b0;
    run_seq("clean_press", 20, P7, 1'b0, 7, 1'b1);
    release_key("clean_release");

    // Press bounce: two cycles low then released.
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) btn_raw = 1'b0;
      if (k == 3) btn_raw = 1'b1;
      tick();
      check("bounce_pulse", 32'(pulse), 32'd0);
      check("bounce_level", 32'(level), 32'd0);
      check("bounce_busy", 32'(busy), 32'((k == 3) || (k == 4)));
    end
    $display("press_bounce: 10 edges checked");

    // Auto-repeat cadence.
    repeat_en = 1'b1;
    btn_raw = 1'b0;
    run_seq("auto_repeat", 30, REP_MASK, 1'b0, 7, 1'b1);
    repeat_en = 1'b0;
    release_key("repeat_release");

    // Release glitch while held.
    press("glitch_press");
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) btn_raw = 1'b1;
      if (k == 3) btn_raw = 1'b0;
      tick();
      check("glitch_pulse", 32'(pulse), 32'd0);
      check("glitch_level", 32'(level), 32'd1);
      check("glitch_busy", 32'(busy), 32'd1);
    end
    $display("release_glitch: 12 edges checked");
    release_key("glitch_release");
    run_seq("idle_gap", 20, NONE, 1'b0, 21, 1'b0);
    press("repress");
    release_key("repress_release");

    // clr during PRESS_CHK, then resume with the key still held.
    btn_raw = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("pre_clr_pulse", 32'(pulse), 32'd0);
    end
    clr = 1'b1;
    tick();
    check("midclr_pulse", 32'(pulse), 32'd0);
    check("midclr_level", 32'(level), 32'd0);
    check("midclr_busy", 32'(busy), 32'd0);
    clr = 1'b0;
    run_seq("clr_resume", 10, P7, 1'b0, 7, 1'b1);

    // clr while HELD drops level immediately.
    clr = 1'b1;
    btn_raw = 1'b1;
    tick();
    check("heldclr_level", 32'(level), 32'd0);
    check("heldclr_busy", 32'(busy), 32'd0);
    clr = 1'b0;
    run_seq("after_heldclr", 8, NONE, 1'b0, 9, 1'b0);

    // Five presses into a model of the 8-bit counter.
    pulse_total = 8'd0;
    for (int i = 0; i < 5; i++) begin
      press("count_press");
      release_key("count_release");
    end
    check("hex0_digit", 32'(pulse_total[3:0]), 32'd5);
    check("hex1_digit", 32'(pulse_total[7:4]), 32'd0);
    $display("counter: value %0d", pulse_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
